// File: rtl/accu_pkg.sv
// Shared definitions for the accumulator core: opcode encoding, FSM states
// and the ALU operation select used between the core and alu_flags.
package accu_pkg;

  localparam logic [3:0] OPC_NOP   = 4'h0;
  localparam logic [3:0] OPC_LDI   = 4'h1;
  localparam logic [3:0] OPC_LDR   = 4'h2;
  localparam logic [3:0] OPC_STR   = 4'h3;
  localparam logic [3:0] OPC_ADD   = 4'h4;
  localparam logic [3:0] OPC_SUB   = 4'h5;
  localparam logic [3:0] OPC_AND   = 4'h6;
  localparam logic [3:0] OPC_OR    = 4'h7;
  localparam logic [3:0] OPC_XOR   = 4'h8;
  localparam logic [3:0] OPC_ADDI  = 4'h9;
  localparam logic [3:0] OPC_JMP   = 4'hA;
  localparam logic [3:0] OPC_JZ    = 4'hB;
  localparam logic [3:0] OPC_JC    = 4'hC;
  localparam logic [3:0] OPC_RSTPC = 4'hD;
  localparam logic [3:0] OPC_OUT   = 4'hE;
  localparam logic [3:0] OPC_HLT   = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  // PASS forwards IN1 unchanged; used for LDI and LDR.
  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_OR   = 3'd4;
  localparam logic [2:0] ALU_XOR  = 3'd5;

  // Opcodes whose ALU result replaces ACC and refreshes Z.
  function automatic logic writes_acc(input logic [3:0] opc);
    case (opc)
      OPC_LDI, OPC_LDR, OPC_ADD, OPC_SUB,
      OPC_AND, OPC_OR, OPC_XOR, OPC_ADDI: writes_acc = 1'b1;
      default:                            writes_acc = 1'b0;
    endcase
  endfunction

  // Opcodes that also refresh C from the ALU carry/borrow.
  function automatic logic writes_carry(input logic [3:0] opc);
    case (opc)
      OPC_ADD, OPC_SUB, OPC_ADDI: writes_carry = 1'b1;
      default:                    writes_carry = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_flags.sv
// Combinational ALU for the accumulator core. CARRY is the carry out of an
// add, the borrow (IN0 < IN1) of a subtract, and 0 for every other operation.
module alu_flags
  import accu_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] IN0,
  input  logic [DATA_WIDTH-1:0] IN1,
  input  logic [2:0]            OP,
  output logic [DATA_WIDTH-1:0] OUT,
  output logic                  CARRY
);

  logic [DATA_WIDTH:0] sum;
  logic [DATA_WIDTH:0] diff;

  // One extra bit on both operands puts carry/borrow in the top bit.
  assign sum  = {1'b0, IN0} + {1'b0, IN1};
  assign diff = {1'b0, IN0} - {1'b0, IN1};

  always_comb begin
    OUT   = IN1;
    CARRY = 1'b0;
    case (OP)
      ALU_ADD: begin
        OUT   = sum[DATA_WIDTH-1:0];
        CARRY = sum[DATA_WIDTH];
      end
      ALU_SUB: begin
        OUT   = diff[DATA_WIDTH-1:0];
        CARRY = diff[DATA_WIDTH];
      end
      ALU_AND: OUT = IN0 & IN1;
      ALU_OR:  OUT = IN0 | IN1;
      ALU_XOR: OUT = IN0 ^ IN1;
      default: OUT = IN1;
    endcase
  end

endmodule

// File: rtl/accu_core.sv
// Accumulator CPU core: run/halt FSM, PC, ACC, Z/C flags, register file and
// output port. One instruction from the async program memory per RUN cycle.
module accu_core
  import accu_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int OP_WIDTH   = 4,
  parameter int PC_WIDTH   = 4,
  parameter int NUM_REGS   = 4
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         START,
  output logic [PC_WIDTH-1:0]          PC,
  input  logic [OP_WIDTH+DATA_WIDTH-1:0] INSTR,
  output logic [DATA_WIDTH-1:0]        ACC_OUT,
  output logic [DATA_WIDTH-1:0]        OUT_DATA,
  output logic                         OUT_VALID,
  output logic                         HALTED,
  output logic                         RUNNING,
  output logic [1:0]                   DBG_STATE,
  output logic                         FLAG_Z,
  output logic                         FLAG_C
);

  localparam int RI_W = $clog2(NUM_REGS);

  state_t state, state_next;

  logic [PC_WIDTH-1:0]   pc, pc_next, pc_inc, target;
  logic [DATA_WIDTH-1:0] acc, acc_next;
  logic                  z, z_next, c, c_next;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  reg_we;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid, out_we;

  logic [3:0]            opc;
  logic [DATA_WIDTH-1:0] arg;
  logic [RI_W-1:0]       idx;
  logic [DATA_WIDTH-1:0] reg_rd;

  logic [2:0]            alu_op;
  logic [DATA_WIDTH-1:0] alu_in1, alu_out;
  logic                  alu_carry;

  assign opc    = 4'(INSTR[OP_WIDTH+DATA_WIDTH-1 -: OP_WIDTH]);
  assign arg    = INSTR[DATA_WIDTH-1:0];
  assign idx    = arg[RI_W-1:0];
  assign reg_rd = regs[idx];
  assign pc_inc = pc + PC_WIDTH'(1);
  assign target = PC_WIDTH'(arg);

  always_comb begin
    alu_op  = ALU_PASS;
    alu_in1 = reg_rd;
    case (opc)
      OPC_LDI:  alu_in1 = arg;
      OPC_ADD:  alu_op  = ALU_ADD;
      OPC_SUB:  alu_op  = ALU_SUB;
      OPC_AND:  alu_op  = ALU_AND;
      OPC_OR:   alu_op  = ALU_OR;
      OPC_XOR:  alu_op  = ALU_XOR;
      OPC_ADDI: begin
        alu_op  = ALU_ADD;
        alu_in1 = arg;
      end
      default: ;
    endcase
  end

  alu_flags #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .IN0  (acc),
    .IN1  (alu_in1),
    .OP   (alu_op),
    .OUT  (alu_out),
    .CARRY(alu_carry)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Jumps read z/c as registered, i.e. the flags left by the previous
  // instruction; they never see the current cycle's ALU result.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    acc_next   = acc;
    z_next     = z;
    c_next     = c;
    reg_we     = 1'b0;
    out_we     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (START) state_next = ST_RUN;
      end
      ST_HALT: begin
        if (START) begin
          state_next = ST_RUN;
          pc_next    = pc_inc;
        end
      end
      ST_RUN: begin
        pc_next = pc_inc;
        if (writes_acc(opc)) begin
          acc_next = alu_out;
          z_next   = (alu_out == '0);
        end
        if (writes_carry(opc)) c_next = alu_carry;
        case (opc)
          OPC_STR:   reg_we  = 1'b1;
          OPC_JMP:   pc_next = target;
          OPC_JZ:    if (z) pc_next = target;
          OPC_JC:    if (c) pc_next = target;
          OPC_RSTPC: pc_next = '0;
          OPC_OUT:   out_we  = 1'b1;
          OPC_HLT: begin
            state_next = ST_HALT;
            pc_next    = pc;
          end
          default: ;
        endcase
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc        <= '0;
      acc       <= '0;
      z         <= 1'b0;
      c         <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      pc        <= pc_next;
      acc       <= acc_next;
      z         <= z_next;
      c         <= c_next;
      out_valid <= out_we;
      if (out_we) out_data <= acc;
      if (reg_we) regs[idx] <= acc;
    end
  end

  // OUT_VALID is a one-cycle strobe with no back-pressure: OUT_DATA carries a
  // new value exactly in the cycle OUT_VALID is high and must be taken then.
  assign PC        = pc;
  assign ACC_OUT   = acc;
  assign OUT_DATA  = out_data;
  assign OUT_VALID = out_valid;
  assign HALTED    = (state == ST_HALT);
  assign RUNNING   = (state == ST_RUN);
  assign DBG_STATE = state;
  assign FLAG_Z    = z;
  assign FLAG_C    = c;

endmodule

// File: tb/tb_accu_core.sv
// Bench for accu_core: an instruction-level reference model predicts final
// architectural state and the OUT stream; a monitor checks every OUT pulse.
module tb_accu_core;
  import accu_pkg::ST_IDLE;

  localparam int DW = 8;
  localparam int OW = 4;
  localparam int PW = 4;
  localparam int NR = 4;
  localparam int DEPTH = 16;

  localparam int I_NOP = 0, I_LDI = 1, I_LDR = 2, I_STR = 3, I_ADD = 4, I_SUB = 5;
  localparam int I_AND = 6, I_OR = 7, I_XOR = 8, I_ADDI = 9, I_JMP = 10, I_JZ = 11;
  localparam int I_JC = 12, I_RSTPC = 13, I_OUT = 14, I_HLT = 15;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          START = 1'b0;
  logic [PW-1:0] PC;
  logic [OW+DW-1:0] INSTR;
  logic [DW-1:0] ACC_OUT, OUT_DATA;
  logic          OUT_VALID, HALTED, RUNNING;
  logic [1:0]    DBG_STATE;
  logic          FLAG_Z, FLAG_C;

  logic [OW+DW-1:0] mem [DEPTH];
  logic [DW-1:0]    exp_q[$];

  int checks = 0;
  int failures = 0;
  int m_pc, m_acc, m_z, m_c;
  int m_r [NR];

  always #5 CLK = ~CLK;

  assign INSTR = mem[PC];

  accu_core #(
    .DATA_WIDTH(DW), .OP_WIDTH(OW), .PC_WIDTH(PW), .NUM_REGS(NR)
  ) dut (
    .CLK(CLK), .RST(RST), .START(START), .PC(PC), .INSTR(INSTR),
    .ACC_OUT(ACC_OUT), .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID),
    .HALTED(HALTED), .RUNNING(RUNNING), .DBG_STATE(DBG_STATE),
    .FLAG_Z(FLAG_Z), .FLAG_C(FLAG_C)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] ins(input int op, input int arg);
    logic [31:0] o, a;
    o = op;
    a = arg;
    return {o[3:0], a[7:0]};
  endfunction

  // Monitor: every OUT_VALID pulse must match the next predicted output.
  always @(negedge CLK) begin
    if (OUT_VALID === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL out_unexpected actual=0x%0h required=no_output", OUT_DATA);
      end else begin
        check("out_data", OUT_DATA, exp_q.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic model_reset();
    m_pc = 0; m_acc = 0; m_z = 0; m_c = 0;
    for (int i = 0; i < NR; i++) m_r[i] = 0;
  endtask

  // Instruction-level reference: executes up to max_steps instructions.
  task automatic model_run(input int max_steps, output int steps, output bit halted);
    logic [11:0] w;
    int op, arg, idx, tgt, nxt, s;
    halted = 1'b0;
    steps = 0;
    while (steps < max_steps && !halted) begin
      w = mem[m_pc];
      op = int'(w[11:8]);
      arg = int'(w[7:0]);
      idx = arg % NR;
      tgt = arg % DEPTH;
      nxt = (m_pc + 1) % DEPTH;
      steps++;
      case (op)
        I_LDI:  begin m_acc = arg; m_z = (m_acc == 0); end
        I_LDR:  begin m_acc = m_r[idx]; m_z = (m_acc == 0); end
        I_STR:  m_r[idx] = m_acc;
        I_ADD:  begin s = m_acc + m_r[idx]; m_c = (s > 255); m_acc = s % 256; m_z = (m_acc == 0); end
        I_SUB:  begin m_c = (m_acc < m_r[idx]); m_acc = (m_acc - m_r[idx] + 256) % 256; m_z = (m_acc == 0); end
        I_AND:  begin m_acc = m_acc & m_r[idx]; m_z = (m_acc == 0); end
        I_OR:   begin m_acc = m_acc | m_r[idx]; m_z = (m_acc == 0); end
        I_XOR:  begin m_acc = m_acc ^ m_r[idx]; m_z = (m_acc == 0); end
        I_ADDI: begin s = m_acc + arg; m_c = (s > 255); m_acc = s % 256; m_z = (m_acc == 0); end
        I_JMP:  nxt = tgt;
        I_JZ:   if (m_z != 0) nxt = tgt;
        I_JC:   if (m_c != 0) nxt = tgt;
        I_RSTPC: nxt = 0;
        I_OUT:  exp_q.push_back(8'(m_acc));
        I_HLT:  begin halted = 1'b1; nxt = m_pc; end
        default: ;
      endcase
      m_pc = nxt;
    end
  endtask

  task automatic compare_state(input string tag, input bit halted);
    check({tag, "_pc"}, PC, m_pc);
    check({tag, "_acc"}, ACC_OUT, m_acc);
    check({tag, "_z"}, FLAG_Z, m_z);
    check({tag, "_c"}, FLAG_C, m_c);
    check({tag, "_halted"}, HALTED, halted);
    check({tag, "_running"}, RUNNING, !halted);
  endtask

  // Advance DUT and model together; pulse starts from IDLE/HALT with START
  // held for `hold` edges, the extra ones landing in RUN where they must be ignored.
  task automatic advance(input string tag, input int max_steps, input int hold,
                         input bit pulse, input bit resume);
    int steps;
    bit halted;
    if (resume) m_pc = (m_pc + 1) % DEPTH;
    model_run(max_steps, steps, halted);
    if (pulse) begin
      START = 1'b1;
      repeat (hold) @(negedge CLK);
      START = 1'b0;
      repeat (steps - (hold - 1)) @(negedge CLK);
    end else begin
      repeat (steps) @(negedge CLK);
    end
    compare_state(tag, halted);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    START = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    model_reset();
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  endtask

  initial begin
    int hold, steps;
    bit halted;
    clear_mem();
    do_reset();

    check("rst_pc", PC, 0);
    check("rst_acc", ACC_OUT, 0);
    check("rst_out_data", OUT_DATA, 0);
    check("rst_out_valid", OUT_VALID, 0);
    check("rst_halted", HALTED, 0);
    check("rst_running", RUNNING, 0);
    check("rst_state", DBG_STATE, ST_IDLE);
    check("rst_z", FLAG_Z, 0);
    check("rst_c", FLAG_C, 0);
    repeat (3) @(negedge CLK);
    check("idle_hold_pc", PC, 0);
    check("idle_hold_running", RUNNING, 0);

    // Basic program: 5 + 3 out, then halt at 5.
    mem[0] = ins(I_LDI, 5); mem[1] = ins(I_STR, 1); mem[2] = ins(I_LDI, 3);
    mem[3] = ins(I_ADD, 1); mem[4] = ins(I_OUT, 0); mem[5] = ins(I_HLT, 0);
    advance("p1", 64, 1, 1'b1, 1'b0);
    check("p1_pc_lit", PC, 5);
    check("p1_out_lit", OUT_DATA, 8);
    check("p1_halted_lit", HALTED, 1);

    // Carry out to zero, then JZ taken.
    do_reset(); clear_mem();
    mem[0] = ins(I_LDI, 8'hFF); mem[1] = ins(I_STR, 0); mem[2] = ins(I_LDI, 1);
    mem[3] = ins(I_ADD, 0); mem[4] = ins(I_JZ, 7); mem[5] = ins(I_HLT, 0);
    mem[6] = ins(I_HLT, 0); mem[7] = ins(I_OUT, 0); mem[8] = ins(I_HLT, 0);
    advance("p2a", 4, 1, 1'b1, 1'b0);
    check("p2_acc_lit", ACC_OUT, 0);
    check("p2_z_lit", FLAG_Z, 1);
    check("p2_c_lit", FLAG_C, 1);
    advance("p2b", 1, 1, 1'b0, 1'b0);
    check("p2_jz_pc_lit", PC, 7);
    advance("p2c", 8, 1, 1'b0, 1'b0);

    // Borrow: JC taken, JZ not taken.
    do_reset(); clear_mem();
    mem[0] = ins(I_LDI, 2); mem[1] = ins(I_STR, 2); mem[2] = ins(I_LDI, 1);
    mem[3] = ins(I_SUB, 2); mem[4] = ins(I_JC, 6); mem[5] = ins(I_HLT, 0);
    mem[6] = ins(I_JZ, 9); mem[7] = ins(I_OUT, 0); mem[8] = ins(I_HLT, 0);
    mem[9] = ins(I_HLT, 0);
    advance("p3a", 4, 1, 1'b1, 1'b0);
    check("p3_acc_lit", ACC_OUT, 8'hFF);
    check("p3_c_lit", FLAG_C, 1);
    check("p3_z_lit", FLAG_Z, 0);
    advance("p3b", 1, 1, 1'b0, 1'b0);
    check("p3_jc_pc_lit", PC, 6);
    advance("p3c", 1, 1, 1'b0, 1'b0);
    check("p3_jz_pc_lit", PC, 7);
    advance("p3d", 8, 1, 1'b0, 1'b0);

    // PC wrap over 16 NOPs.
    do_reset(); clear_mem();
    advance("wrap", 16, 1, 1'b1, 1'b0);
    check("wrap_pc_lit", PC, 0);
    advance("wrap1", 1, 1, 1'b0, 1'b0);

    // Register index uses only the low bits of ARG.
    do_reset(); clear_mem();
    mem[0] = ins(I_LDI, 8'h2A); mem[1] = ins(I_STR, 8'h07); mem[2] = ins(I_LDI, 0);
    mem[3] = ins(I_LDR, 8'h03); mem[4] = ins(I_OUT, 0); mem[5] = ins(I_LDI, 0);
    mem[6] = ins(I_LDR, 8'hFF); mem[7] = ins(I_OUT, 0); mem[8] = ins(I_HLT, 0);
    advance("idx", 20, 1, 1'b1, 1'b0);
    check("idx_acc_lit", ACC_OUT, 8'h2A);

    // START held into RUN, halt, idle in HALT, resume at HLT+1.
    do_reset(); clear_mem();
    mem[0] = ins(I_LDI, 1); mem[1] = ins(I_ADDI, 1); mem[2] = ins(I_ADDI, 1);
    mem[3] = ins(I_HLT, 0); mem[4] = ins(I_ADDI, 4); mem[5] = ins(I_OUT, 0);
    mem[6] = ins(I_HLT, 0);
    advance("hr1", 20, 3, 1'b1, 1'b0);
    check("hr1_pc_lit", PC, 3);
    check("hr1_acc_lit", ACC_OUT, 3);
    repeat (3) @(negedge CLK);
    check("halt_hold_pc", PC, 3);
    check("halt_hold_halted", HALTED, 1);
    advance("hr2", 20, 1, 1'b1, 1'b1);
    check("hr2_pc_lit", PC, 6);
    check("hr2_out_lit", OUT_DATA, 7);

    // Spin loop on own address.
    do_reset(); clear_mem();
    mem[0] = ins(I_LDI, 9); mem[1] = ins(I_JMP, 1);
    advance("spin", 10, 1, 1'b1, 1'b0);
    check("spin_pc_lit", PC, 1);

    // Reset (with START high) while ADD is being decoded.
    do_reset(); clear_mem();
    mem[0] = ins(I_LDI, 5); mem[1] = ins(I_OUT, 0); mem[2] = ins(I_STR, 1);
    mem[3] = ins(I_ADD, 1); mem[4] = ins(I_OUT, 0); mem[5] = ins(I_HLT, 0);
    advance("pre_rst", 3, 1, 1'b1, 1'b0);
    RST = 1'b1;
    START = 1'b1;
    @(negedge CLK);
    check("mid_rst_pc", PC, 0);
    check("mid_rst_acc", ACC_OUT, 0);
    check("mid_rst_out_data", OUT_DATA, 0);
    check("mid_rst_out_valid", OUT_VALID, 0);
    check("mid_rst_running", RUNNING, 0);
    check("mid_rst_halted", HALTED, 0);
    check("mid_rst_state", DBG_STATE, ST_IDLE);
    check("mid_rst_c", FLAG_C, 0);
    RST = 1'b0;
    START = 1'b0;
    model_reset();
    clear_mem();
    mem[0] = ins(I_LDR, 1); mem[1] = ins(I_OUT, 0); mem[2] = ins(I_HLT, 0);
    advance("post_rst", 10, 1, 1'b1, 1'b0);

    // Random programs against the reference model.
    for (int it = 0; it < 25; it++) begin
      do_reset();
      for (int i = 0; i < DEPTH; i++) mem[i] = 12'($urandom_range(0, 4095));
      hold = $urandom_range(1, 3);
      model_run(40, steps, halted);
      if (halted && steps < 3) hold = 1;
      START = 1'b1;
      repeat (hold) @(negedge CLK);
      START = 1'b0;
      repeat (steps - (hold - 1)) @(negedge CLK);
      compare_state("rand", halted);
    end

    @(negedge CLK);
    @(negedge CLK);
    check("final_queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
